prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256: largest accepted program length in 16-bit words.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port start  input  1  one-cycle request to begin a load session; sampled only in IDLE.
REQ-005 Port rx_valid  input  1  byte-stream source has a byte on rx_data.
REQ-006 Port rx_data  input  8  byte from the stream.
REQ-007 Port rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both 1.
REQ-008 Port mem_addr  output  16  instruction-memory word address for the write.
REQ-009 Port mem_wdata  output  16  instruction word to write.
REQ-010 Port mem_we  output  1  instruction-memory write enable, one cycle per word.
REQ-011 Port cpu_hold  output  1  holds the CPU in reset while a session is active.
REQ-012 Port busy  output  1  session in progress (any state other than IDLE).
REQ-013 Port done  output  1  one-cycle pulse on successful completion.
REQ-014 Port err  output  1  sticky error flag; cleared by the next accepted start or by rst.

Function
REQ-015 FSM states SHALL be: IDLE, CNT_LO, CNT_HI, DATA_LO, DATA_HI, CHK, FIN.
REQ-016 Stream format SHALL be: count N (low byte, then high byte), then N words (each low byte, then high byte), then the checksum byte (only if CHECKSUM_EN).
REQ-017 IDLE SHALL go to CNT_LO on start and clear err; start in any other state SHALL be ignored.
REQ-018 rx_ready SHALL be 1 exactly in CNT_LO, CNT_HI, DATA_LO, DATA_HI, CHK; each transfer advances the FSM by one state.
REQ-019 After CNT_HI: N=0 SHALL go to CHK (or FIN); N>MAX_WORDS SHALL set err and go to IDLE without writing; otherwise SHALL go to DATA_LO with word index 0.
REQ-020 On the DATA_HI transfer, mem_wdata={rx_data, stored low byte} and mem_addr=index SHALL be registered; mem_we=1 SHALL follow in the next cycle, for one cycle only.
REQ-021 Index SHALL increment after each write; when it reaches N, the FSM SHALL go to CHK (or FIN), otherwise to DATA_LO.
REQ-022 Outside write cycles, mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold their last values.
REQ-023 cpu_hold SHALL equal busy; FIN SHALL last one cycle with done=1 and then return to IDLE.
REQ-024 rx_valid low SHALL stall the FSM indefinitely with no timeout; rx_data is ignored when rx_ready=0.

Reset
REQ-025 rst SHALL put the FSM in IDLE from any state, mid-session included, and SHALL drive rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0, index=0, checksum=0.
REQ-026 Words already written before rst SHALL NOT be rolled back.

Configuration
REQ-027 Macro PROG_LOADER_CHECKSUM_EN.
- Defined: an 8-bit running sum (mod 256) of all bytes including the count bytes; CHK accepts one byte; match -> FIN, mismatch -> err=1 and IDLE with no done.
- Undefined: no CHK state and no checksum logic; the FSM goes from the last word (or N=0) directly to FIN.

Verification
REQ-028 start, stream 02 00 34 12 CD AB (macro off) -> writes 0x1234 @0 and 0xABCD @1, one mem_we cycle each; done pulse; cpu_hold 1 from the cycle after start through FIN.
REQ-029 start, count 00 00 (macro off) -> no mem_we, done pulses one cycle after the CNT_HI transfer.
REQ-030 start, count 01 02 (N=513 > 256) -> err=1, FSM back in IDLE, no mem_we, no done, cpu_hold=0.
REQ-031 Macro on, stream 01 00 11 22 + checksum 0x34 -> write 0x2211 @0 and done; repeat with checksum 0x35 -> err=1, no done.
REQ-032 rx_valid toggled 1/0 each cycle during a 3-word load -> identical writes, with mem_we only on the cycles after DATA_HI transfers.
REQ-033 rst asserted after the first word of N=4 -> next cycle all outputs at reset values; a new start and a full stream then load correctly from index 0.

Source files
------------

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : prog_loader                                               |
// | Purpose  : Receives a byte-streamed program (count, words, optional  |
// |            checksum) and writes it to instruction memory while the   |
// |            CPU is held in reset.                                     |
// | Options  : PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module prog_loader #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CNT_LO  = 3'd1;
    localparam logic [2:0] c_CNT_HI  = 3'd2;
    localparam logic [2:0] c_DATA_LO = 3'd3;
    localparam logic [2:0] c_DATA_HI = 3'd4;
    localparam logic [2:0] c_FIN     = 3'd6;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CHK       = 3'd5;
    localparam logic [2:0] c_POST_DATA = c_CHK;
`else
    localparam logic [2:0] c_POST_DATA = c_FIN;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [7:0]  r_lo_byte;
    logic [15:0] r_count;
    logic [15:0] r_index;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_mem_we;
    logic        r_err;
    logic [15:0] w_rx_word;
    logic        w_count_zero;
    logic        w_count_over;
    logic        w_last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
    logic        w_csum_ok;
`endif

    // The high byte on rx_data combined with the previously captured low byte.
    assign w_rx_word    = {rx_data, r_lo_byte};
    assign w_count_zero = (w_rx_word == 16'd0);
    assign w_count_over = (32'(w_rx_word) > MAX_WORDS);
    assign w_last_word  = ((r_index + 16'd1) == r_count);
`ifdef PROG_LOADER_CHECKSUM_EN
    assign w_csum_ok    = (rx_data == r_csum);
`endif

`ifdef PROG_LOADER_CHECKSUM_EN
    assign rx_ready = (r_state == c_CNT_LO)  || (r_state == c_CNT_HI) ||
                      (r_state == c_DATA_LO) || (r_state == c_DATA_HI) ||
                      (r_state == c_CHK);
`else
    assign rx_ready = (r_state == c_CNT_LO)  || (r_state == c_CNT_HI) ||
                      (r_state == c_DATA_LO) || (r_state == c_DATA_HI);
`endif

    assign busy      = (r_state != c_IDLE);
    assign cpu_hold  = busy;
    assign done      = (r_state == c_FIN);
    assign err       = r_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // rx_ready is 1 in every receiving state, so rx_valid alone marks a transfer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_CNT_LO;
                end
            end
            c_CNT_LO: begin
                if (rx_valid) begin
                    w_next_state = c_CNT_HI;
                end
            end
            c_CNT_HI: begin
                if (rx_valid) begin
                    if (w_count_zero) begin
                        w_next_state = c_POST_DATA;
                    end else if (w_count_over) begin
                        w_next_state = c_IDLE;
                    end else begin
                        w_next_state = c_DATA_LO;
                    end
                end
            end
            c_DATA_LO: begin
                if (rx_valid) begin
                    w_next_state = c_DATA_HI;
                end
            end
            c_DATA_HI: begin
                if (rx_valid) begin
                    w_next_state = w_last_word ? c_POST_DATA : c_DATA_LO;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            c_CHK: begin
                if (rx_valid) begin
                    w_next_state = w_csum_ok ? c_FIN : c_IDLE;
                end
            end
`endif
            c_FIN: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo_byte   <= 8'd0;
            r_count     <= 16'd0;
            r_index     <= 16'd0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 16'd0;
            r_mem_we    <= 1'b0;
            r_err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_err   <= 1'b0;
                        r_index <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum  <= 8'd0;
`endif
                    end
                end
                c_CNT_LO, c_DATA_LO: begin
                    if (rx_valid) begin
                        r_lo_byte <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum    <= r_csum + rx_data;
`endif
                    end
                end
                c_CNT_HI: begin
                    if (rx_valid) begin
                        r_count <= w_rx_word;
                        r_index <= 16'd0;
                        if (w_count_over) begin
                            r_err <= 1'b1;
                        end
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum  <= r_csum + rx_data;
`endif
                    end
                end
                c_DATA_HI: begin
                    if (rx_valid) begin
                        r_mem_addr  <= r_index;
                        r_mem_wdata <= w_rx_word;
                        r_mem_we    <= 1'b1;
                        r_index     <= r_index + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum      <= r_csum + rx_data;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                c_CHK: begin
                    if (rx_valid && !w_csum_ok) begin
                        r_err <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_prog_loader                                            |
// | Purpose  : Self-checking bench for prog_loader; honours              |
// |            PROG_LOADER_CHECKSUM_EN when it is defined.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_prog_loader;

    localparam int unsigned MAX_W = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_bad = 0;
    bit vph = 1'b1;

    logic [15:0] stim_words[$];
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cyc_q[$];

    prog_loader #(.MAX_WORDS(MAX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction-memory side: log every write and every done pulse with its cycle.
    always @(negedge clk) begin
        if (cpu_hold !== busy) hold_bad++;
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) done_cyc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":rx_ready"},  32'(rx_ready),  32'd0);
        check({tag, ":mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, ":mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, ":mem_we"},    32'(mem_we),    32'd0);
        check({tag, ":cpu_hold"},  32'(cpu_hold),  32'd0);
        check({tag, ":busy"},      32'(busy),      32'd0);
        check({tag, ":done"},      32'(done),      32'd0);
        check({tag, ":err"},       32'(err),       32'd0);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":busy_after_start"}, 32'(busy),     32'd1);
        check({tag, ":hold_after_start"}, 32'(cpu_hold), 32'd1);
        check({tag, ":err_cleared"},      32'(err),      32'd0);
    endtask

    // mode 0: always valid; 1: random stalls plus stray start pulses; 2: valid toggles each cycle.
    task automatic send_byte(input logic [7:0] b, input int mode, output int xcyc);
        bit sent;
        int budget;
        sent   = 1'b0;
        budget = 0;
        xcyc   = -1;
        while (!sent && budget < 100) begin
            @(negedge clk);
            budget++;
            case (mode)
                1: begin
                    rx_valid = ($urandom_range(0, 2) != 0);
                    start    = ($urandom_range(0, 7) == 0);
                end
                2: begin
                    rx_valid = vph;
                    vph      = ~vph;
                end
                default: rx_valid = 1'b1;
            endcase
            rx_data = rx_valid ? b : 8'($urandom);
            if (rx_valid && rx_ready) begin
                sent = 1'b1;
                xcyc = cyc;
            end
        end
        check("xfer_accepted", 32'(sent), 32'd1);
    endtask

    task automatic end_stream();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, ":idle_reached"}, 32'(busy), 32'd0);
    endtask

    // Reference model: expected writes are simply stim_words[i] at address i, one
    // cycle after its high byte is accepted; done follows the last accepted byte.
    task automatic run_session(input int n, input int mode, input bit bad_csum, input string tag);
        logic [7:0]  sum;
        logic [15:0] w;
        int c, last_c, wr_base, done_base;
        bit over, bad_eff, exp_done;
        int exp_cyc[$];
        over    = (n > int'(MAX_W));
        bad_eff = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        bad_eff = bad_csum && !over;
`endif
        while (!over && stim_words.size() < n) stim_words.push_back(16'($urandom));
        wr_base   = wr_addr_q.size();
        done_base = done_cyc_q.size();
        hold_bad  = 0;
        do_start(tag);
        sum = 8'(n) + 8'(n >> 8);
        send_byte(8'(n), mode, c);
        send_byte(8'(n >> 8), mode, c);
        last_c = c;
        if (!over) begin
            for (int i = 0; i < n; i++) begin
                w = stim_words[i];
                send_byte(w[7:0], mode, c);
                send_byte(w[15:8], mode, c);
                sum = sum + w[7:0] + w[15:8];
                exp_cyc.push_back(c + 1);
                last_c = c;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            send_byte(bad_eff ? sum + 8'd1 : sum, mode, c);
            last_c = c;
`endif
        end
        end_stream();
        wait_idle(tag);
        repeat (2) @(negedge clk);
        check({tag, ":wr_count"}, 32'(wr_addr_q.size() - wr_base), 32'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size(); i++) begin
            if (wr_base + i < wr_addr_q.size()) begin
                check({tag, ":wr_addr"}, 32'(wr_addr_q[wr_base + i]), 32'(i));
                check({tag, ":wr_data"}, 32'(wr_data_q[wr_base + i]), 32'(stim_words[i]));
                check({tag, ":wr_cycle"}, 32'(wr_cyc_q[wr_base + i]), 32'(exp_cyc[i]));
            end
        end
        exp_done = !over && !bad_eff;
        check({tag, ":done_count"}, 32'(done_cyc_q.size() - done_base), 32'(exp_done));
        if (exp_done && done_cyc_q.size() > done_base)
            check({tag, ":done_cycle"}, 32'(done_cyc_q[done_base]), 32'(last_c + 1));
        check({tag, ":err"},       32'(err),      32'(over || bad_eff));
        check({tag, ":hold_idle"}, 32'(cpu_hold), 32'd0);
        check({tag, ":we_idle"},   32'(mem_we),   32'd0);
        check({tag, ":hold_eq_busy"}, 32'(hold_bad), 32'd0);
        stim_words.delete();
    endtask

    initial begin
        logic [15:0] tw;
        int tc, wb;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        stim_words = '{16'h1234, 16'hABCD};
        run_session(2, 0, 1'b0, "two_words");

        run_session(0, 0, 1'b0, "n_zero");

        run_session(513, 0, 1'b0, "n_over");
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);

        stim_words = '{16'h2211};
        run_session(1, 0, 1'b0, "csum_good");
        stim_words = '{16'h2211};
        run_session(1, 0, 1'b1, "csum_bad");

        run_session(3, 2, 1'b0, "valid_toggle");

        // Reset in the middle of a four-word load, right after the first write.
        wb = wr_addr_q.size();
        do_start("rst_mid");
        tw = 16'($urandom);
        send_byte(8'd4, 0, tc);
        send_byte(8'd0, 0, tc);
        send_byte(tw[7:0], 0, tc);
        send_byte(tw[15:8], 0, tc);
        @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        check("rst_mid:wr_count", 32'(wr_addr_q.size() - wb), 32'd1);
        if (wr_addr_q.size() > wb) begin
            check("rst_mid:wr_addr", 32'(wr_addr_q[wb]), 32'd0);
            check("rst_mid:wr_data", 32'(wr_data_q[wb]), 32'(tw));
        end
        rst = 1'b0;
        @(negedge clk);
        run_session(4, 0, 1'b0, "after_rst");

        for (int k = 0; k < 6; k++)
            run_session(int'($urandom_range(1, 10)), 1, ($urandom_range(0, 3) == 0), "random");

        run_session(int'(MAX_W), 0, 1'b0, "n_max");
        run_session(int'(MAX_W) + 1, 0, 1'b0, "n_max_plus1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
